// File: rtl/inst_fetch_responder.sv
// Instruction-side burst responder: fetches BURST_LEN little-endian words byte by byte
// from a RAM port with one cycle of read latency and streams them back to the fetcher.
module inst_fetch_responder #(
  parameter int BURST_LEN  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  enable_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic                  reset_in,
  input  logic                  lsu_busy_in,
  input  logic [7:0]            mem_din_in,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out,
  output logic [31:0]           inst_out,
  output logic                  one_inst_finish_out,
  output logic                  end_out,
  output logic                  aviliable_out
);

  localparam int BYTES = 4 * BURST_LEN;
  localparam int CNT_W = $clog2(BYTES + 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [ADDR_WIDTH-1:0]   mem_a_reg;
  logic [CNT_W-1:0]        issue_reg;
  logic [CNT_W-1:0]        recv_reg;
  logic                    data_valid_reg;
  logic [23:0]             asm_reg;
  logic [31:0]             inst_reg;
  logic                    one_reg;
  logic                    end_reg;

  logic start;
  logic abort;
  logic byte_take;
  logic last_byte;

  // Held low during reset so every output reads 0 while rst_in is asserted.
  assign aviliable_out = rst_in && (state_reg == IDLE) && !lsu_busy_in && !end_reg;

  assign start     = rdy_in && enable_in && aviliable_out;
  assign abort     = rdy_in && (state_reg == READ) && reset_in;
  assign byte_take = rdy_in && (state_reg == READ) && !reset_in && data_valid_reg;
  assign last_byte = byte_take && (recv_reg == CNT_W'(BYTES - 1));

  assign mem_a_out           = mem_a_reg;
  assign mem_wr_out          = 1'b0;
  assign inst_out            = inst_reg;
  assign one_inst_finish_out = one_reg;
  assign end_out             = end_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (abort || last_byte) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base_reg       <= '0;
      mem_a_reg      <= '0;
      issue_reg      <= '0;
      recv_reg       <= '0;
      data_valid_reg <= 1'b0;
      asm_reg        <= '0;
      inst_reg       <= '0;
      one_reg        <= 1'b0;
      end_reg        <= 1'b0;
    end else if (rdy_in) begin
      one_reg <= 1'b0;
      end_reg <= 1'b0;
      if (start) begin
        base_reg       <= address_in;
        mem_a_reg      <= address_in;
        issue_reg      <= CNT_W'(1);
        recv_reg       <= '0;
        // The RAM answers one cycle late, so the first READ cycle carries no byte.
        data_valid_reg <= 1'b0;
      end else if (state_reg == READ) begin
        if (reset_in) begin
          data_valid_reg <= 1'b0;
        end else begin
          data_valid_reg <= 1'b1;
          if (issue_reg < CNT_W'(BYTES)) begin
            mem_a_reg <= base_reg + ADDR_WIDTH'(issue_reg);
            issue_reg <= issue_reg + CNT_W'(1);
          end
          if (data_valid_reg) begin
            recv_reg <= recv_reg + CNT_W'(1);
            case (recv_reg[1:0])
              2'd0: asm_reg[7:0]   <= mem_din_in;
              2'd1: asm_reg[15:8]  <= mem_din_in;
              2'd2: asm_reg[23:16] <= mem_din_in;
              default: begin
                inst_reg <= {mem_din_in, asm_reg};
                if (last_byte) end_reg <= 1'b1;
                else           one_reg <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Instruction-side responder of the memory controller; serves the fetcher's burst-read request interface.
- On a request, reads BURST_LEN consecutive 32-bit little-endian words from the byte-wide RAM port.
- Streams each assembled word back with a one-cycle strobe; the final word is marked with end instead.
- Read-only. The data-side arbiter owns the RAM whenever lsu_busy_in is high.

Parameters:
BURST_LEN, 4, instructions per burst (1..64)
ADDR_WIDTH, 32, address width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes all state (RAM output held by same rdy_in)
enable_in  input  1  fetcher burst request (level)
address_in  input  ADDR_WIDTH  burst base address (word-aligned)
reset_in  input  1  fetcher abort of current burst
lsu_busy_in  input  1  data side owns RAM; block must not start
mem_din_in  input  8  RAM read byte (1-cycle latency)
mem_a_out  output  ADDR_WIDTH  RAM byte address
mem_wr_out  output  1  RAM write enable, constant 0
inst_out  output  32  assembled instruction
one_inst_finish_out  output  1  strobe, non-final instruction valid
end_out  output  1  strobe, final instruction valid
aviliable_out  output  1  ready to accept a request

Behaviour:
- Reset (rst_in low, immediate): state IDLE; all outputs 0; counters and assembly register cleared.
- aviliable_out is combinational: (state==IDLE) && !lsu_busy_in && !end_out.
- IDLE: at an edge with enable_in && aviliable_out && rdy_in (edge T0):
  - latch base=address_in;
  - mem_a_out<=base; issue counter=1, receive counter=0;
  - go to READ.
  - enable_in while unavailable: wait, no side effects.
- READ, per rdy_in-high edge:
  - if issue<4*BURST_LEN: mem_a_out<=base+issue, issue++ (mod 2^ADDR_WIDTH wrap). Otherwise hold mem_a_out.
  - byte on mem_din_in in cycle c belongs to mem_a_out of cycle c-1; first valid byte in cycle T0+2.
  - byte k goes to bits [8*(k%4)+7 : 8*(k%4)].
  - on the 4th byte of instruction i: inst_out<=word (registered).
    - i<BURST_LEN-1: one_inst_finish_out=1 for exactly one cycle.
    - i==BURST_LEN-1: end_out=1 for one cycle, one_inst_finish_out=0; state<=IDLE on the same edge.
- Timing: mem_a_out=base+k in cycle T0+1+k. Instruction i visible in cycle T0+6+4i. end_out in cycle T0+4*BURST_LEN+2. aviliable_out high again in cycle T0+4*BURST_LEN+3 (if lsu_busy_in low).
- inst_out holds its value between strobes. Strobes are otherwise 0.
- enable_in is sampled only in IDLE; dropping it mid-burst has no effect.
- reset_in high at an edge in READ:
  - state<=IDLE; in-flight byte discarded; no further strobes.
  - reset_in wins over a simultaneous final-byte completion (no end_out).
- lsu_busy_in is ignored during READ; the burst is never preempted.
- rdy_in low: no register changes; timing extends by the number of stalled cycles.

Test Plan:
- Basic burst: RAM words 0x00000013, 0x00100093, 0x00208113, 0xFFDFF06F at 0x1000; enable at T0 -> mem_a_out 0x1000..0x100F in cycles T0+1..T0+16; one_inst_finish_out with those words in T0+6/T0+10/T0+14; end_out with 0xFFDFF06F at T0+18; aviliable_out=1 at T0+19.
- Arbitration: lsu_busy_in=1 while enable_in=1 for 5 cycles -> aviliable_out=0, mem_a_out unchanged; busy drops -> acceptance on the next edge, timing as scenario 1 from that edge.
- Abort: reset_in pulse at edge ending cycle T0+8 -> only the T0+6 strobe occurs; no end_out; aviliable_out=1 at T0+9; a new request at 0x2000 is then served correctly.
- Async reset: rst_in low mid-cycle at T0+7 -> all outputs 0 immediately without a clock edge; after release, state is IDLE.
- Address wrap: base 0xFFFFFFF8 -> mem_a_out 0xFFFFFFF8..0xFFFFFFFF, then 0x00000000..0x00000007; four words assembled correctly.
- Stall plus back-to-back: rdy_in low for 3 cycles from T0+7 -> all later events shift by +3 with identical data; enable_in re-asserted immediately after end_out -> second burst accepted in cycle T0+4*BURST_LEN+3+3.
